// File: rtl/mips_register_bank_if.sv
// Register bank access bus: two combinational read ports, one write port,
// and the ready flag that rises once the post-reset clear sweep is done.
// The master drives indices and write data; the slave (the bank) returns data.
interface mips_register_bank_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) ();
    logic [ADDR_WIDTH-1:0] read_reg_1;
    logic [ADDR_WIDTH-1:0] read_reg_2;
    logic [ADDR_WIDTH-1:0] write_reg;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  signal_reg_write;
    logic [DATA_WIDTH-1:0] read_data_1;
    logic [DATA_WIDTH-1:0] read_data_2;
    logic                  ready;

    modport master (
        output read_reg_1, read_reg_2, write_reg, write_data, signal_reg_write,
        input  read_data_1, read_data_2, ready
    );

    modport slave (
        input  read_reg_1, read_reg_2, write_reg, write_data, signal_reg_write,
        output read_data_1, read_data_2, ready
    );
endinterface

// File: rtl/mips_register_bank.sv
// MIPS-style register bank: 2**ADDR_WIDTH entries of DATA_WIDTH bits,
// two combinational read ports and one synchronous write port.
// Register 0 is hard-wired to zero. After reset a CLEAR sweep zeroes
// entries 1..DEPTH-1, one per clock; reads return 0 and writes are
// ignored until the sweep finishes and ready rises.
// Optional feature: define REGFILE_BYPASS_EN to forward write_data to a
// read port that addresses the register being written in the same cycle.
module mips_register_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    mips_register_bank_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t                state_q,     state_d;
    logic [ADDR_WIDTH-1:0] clear_idx_q, clear_idx_d;

    // Storage for the bank; entry 0 is never written and never read.
    logic [DATA_WIDTH-1:0] regs_q [DEPTH];

    // Write-port controls for the array, shared by the sweep and normal writes.
    logic                  mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_d;

    // State register: reset restarts the sweep from entry 1.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // pre-edge values regardless of process evaluation order.
        if (rst) begin
            state_q     <= S_CLEAR;
            clear_idx_q <= FIRST_IDX;
        end else begin
            state_q     <= state_d;
            clear_idx_q <= clear_idx_d;
        end
    end

    // Next-state logic: step the sweep index; leave CLEAR after the last entry.
    always_comb begin
        // NOTE: defaults first so every path assigns every output (no latches).
        state_d     = state_q;
        clear_idx_d = clear_idx_q;
        if (state_q == S_CLEAR) begin
            clear_idx_d = clear_idx_q + 1'b1;
            if (clear_idx_q == LAST_IDX) begin
                state_d = S_READY;
            end
        end
    end

    // Array write selection: sweep zeroing in CLEAR, user writes in READY.
    always_comb begin
        mem_we_d   = 1'b0;
        mem_addr_d = bus.write_reg;
        mem_data_d = bus.write_data;
        if (!rst) begin
            if (state_q == S_CLEAR) begin
                mem_we_d   = 1'b1;
                mem_addr_d = clear_idx_q;
                mem_data_d = '0;
            end else if (bus.signal_reg_write && (bus.write_reg != '0)) begin
                mem_we_d   = 1'b1;
            end
        end
    end

    // Array write port.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset term; clearing is done by the sweep so
        // the storage maps onto plain RAM/flops without a reset network.
        if (mem_we_d) begin
            regs_q[mem_addr_d] <= mem_data_d;
        end
    end

    // Outputs: ready flag and combinational reads, zero in CLEAR and for entry 0.
    always_comb begin
        bus.ready       = (state_q == S_READY);
        bus.read_data_1 = '0;
        bus.read_data_2 = '0;
        if (state_q == S_READY) begin
            if (bus.read_reg_1 != '0) begin
                bus.read_data_1 = regs_q[bus.read_reg_1];
            end
            if (bus.read_reg_2 != '0) begin
                bus.read_data_2 = regs_q[bus.read_reg_2];
            end
`ifdef REGFILE_BYPASS_EN
            // Forward a write that lands this cycle to a matching read port.
            if (!rst && bus.signal_reg_write && (bus.write_reg != '0)) begin
                if (bus.write_reg == bus.read_reg_1) begin
                    bus.read_data_1 = bus.write_data;
                end
                if (bus.write_reg == bus.read_reg_2) begin
                    bus.read_data_2 = bus.write_data;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_mips_register_bank.sv
// Bench for mips_register_bank: randomized and directed traffic on a default
// 32x32 instance scored against a behavioural model, plus a directed run on a
// 16-bit x 8-entry instance.
module tb_mips_register_bank;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst   = 1'b1;
    logic rst_s = 1'b1;

    mips_register_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    mips_register_bank_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3))  bus_s ();

    mips_register_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mips_register_bank #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut_s (
        .clk (clk),
        .rst (rst_s),
        .bus (bus_s)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] model_mem [DEPTH];
    bit            m_started = 1'b0;
    bit            m_clear   = 1'b1;
    int            m_left    = 0;

    // Apply one rising edge using the inputs held before that edge.
    function automatic void model_edge();
        if (rst) begin
            m_started = 1'b1;
            m_clear   = 1'b1;
            m_left    = DEPTH - 1;
        end else if (m_started) begin
            if (m_clear) begin
                m_left--;
                if (m_left == 0) begin
                    m_clear = 1'b0;
                    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
                end
            end else if (bus.signal_reg_write && bus.write_reg != 0) begin
                model_mem[bus.write_reg] = bus.write_data;
            end
        end
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        if (m_clear || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (!rst && bus.signal_reg_write && bus.write_reg == a) return bus.write_data;
`endif
        return model_mem[a];
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        string         name;
        logic          ready;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
    } exp_t;

    exp_t sb_q[$];

    // Monitor: one expected entry per cycle, compared at the falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check({e.name, ".ready"}, 32'(bus.ready), 32'(e.ready));
            check({e.name, ".rd1"},   bus.read_data_1, e.rd1);
            check({e.name, ".rd2"},   bus.read_data_2, e.rd2);
        end
    end

    // One clock of stimulus: advance model over the edge, drive, predict.
    task automatic step(input string name, input bit r, input bit we,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        exp_t e;
        @(posedge clk);
        model_edge();
        #1;
        rst                  = r;
        bus.signal_reg_write = we;
        bus.write_reg        = wa;
        bus.write_data       = wd;
        bus.read_reg_1       = a1;
        bus.read_reg_2       = a2;
        if (m_started) begin
            e.name  = name;
            e.ready = !m_clear;
            e.rd1   = model_read(a1);
            e.rd2   = model_read(a2);
            sb_q.push_back(e);
        end
    endtask

    task automatic idle(input string name, input int n);
        for (int i = 0; i < n; i++)
            step(name, 1'b0, 1'b0, AW'($urandom), DW'($urandom), AW'($urandom), AW'($urandom));
    endtask

    task automatic read_all(input string name);
        for (int i = 0; i < DEPTH; i++)
            step(name, 1'b0, 1'b0, '0, '0, AW'(i), AW'(DEPTH - 1 - i));
    endtask

    task automatic random_traffic(input string name, input int n, input bit allow_rst);
        logic [AW-1:0] last_wa = '0;
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] wa = AW'($urandom);
            logic [AW-1:0] a1 = ($urandom_range(0, 2) == 0) ? last_wa : AW'($urandom);
            logic [AW-1:0] a2 = ($urandom_range(0, 2) == 0) ? wa      : AW'($urandom);
            bit r = allow_rst && ($urandom_range(0, 99) == 0);
            step(name, r, 1'($urandom), wa, DW'($urandom), a1, a2);
            last_wa = wa;
        end
    endtask

    initial begin
        int cnt;
        bus.signal_reg_write   = 1'b0;
        bus.write_reg          = '0;
        bus.write_data         = '0;
        bus.read_reg_1         = '0;
        bus.read_reg_2         = '0;
        bus_s.signal_reg_write = 1'b0;
        bus_s.write_reg        = '0;
        bus_s.write_data       = '0;
        bus_s.read_reg_1       = '0;
        bus_s.read_reg_2       = '0;

        // Reset for two edges, then the sweep; reads forced to zero meanwhile.
        step("rst", 1'b1, 1'b0, '0, '0, 5'd3, 5'd7);
        step("rst", 1'b0, 1'b0, '0, '0, 5'd3, 5'd7);
        idle("sweep", 31);
        read_all("post_sweep");

        // Write 30, read 30 and 31.
        step("w30", 1'b0, 1'b1, 5'd30, 32'hFF00_3FFF, 5'd1, 5'd2);
        step("r30", 1'b0, 1'b0, '0, '0, 5'd31, 5'd30);

        // Write to register 0 is discarded.
        step("w0", 1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0);
        step("r0", 1'b0, 1'b0, '0, '0, 5'd0, 5'd0);

        // Same-cycle read of a register being written, then the next cycle.
        step("w5_pre", 1'b0, 1'b1, 5'd5, 32'h1111_1111, 5'd4, 5'd4);
        step("w5_same", 1'b0, 1'b1, 5'd5, 32'h1234_5678, 5'd5, 5'd5);
        step("w5_next", 1'b0, 1'b0, '0, '0, 5'd5, 5'd30);

        // Write coincident with reset is dropped; reset in READY restarts sweep.
        step("w_rst", 1'b1, 1'b1, 5'd9, 32'hCAFE_F00D, 5'd9, 5'd30);
        step("rel", 1'b0, 1'b0, '0, '0, 5'd9, 5'd30);
        idle("sweep2", 31);
        read_all("post_sweep2");

        random_traffic("rand", 400, 1'b0);

        // Reset at sweep edge 10, release, write during CLEAR.
        step("rst3", 1'b1, 1'b0, '0, '0, 5'd1, 5'd2);
        step("rel3", 1'b0, 1'b0, '0, '0, 5'd1, 5'd2);
        idle("sweep3a", 8);
        step("rst_mid", 1'b1, 1'b1, 5'd12, 32'h5555_AAAA, 5'd12, 5'd1);
        step("rel_mid", 1'b0, 1'b1, 5'd12, 32'hAAAA_5555, 5'd12, 5'd1);
        for (int i = 0; i < 30; i++)
            step("clr_wr", 1'b0, 1'b1, AW'($urandom), DW'($urandom), AW'($urandom), AW'($urandom));
        read_all("post_sweep3");

        random_traffic("rand_rst", 600, 1'b1);
        idle("tail", 32);
        read_all("final");

        @(negedge clk);
        @(negedge clk);
        check("sb_drain", 32'(sb_q.size()), 32'd0);

        // Small instance: 8 entries, 16 bits.
        @(posedge clk);
        #1;
        check("small.ready_in_rst", 32'(bus_s.ready), 32'd0);
        rst_s = 1'b0;
        cnt = 0;
        while (bus_s.ready !== 1'b1 && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("small.sweep_edges", 32'(cnt), 32'd7);
        bus_s.read_reg_1 = 3'd7;
        bus_s.read_reg_2 = 3'd6;
        #1;
        check("small.rd7_zero", 32'(bus_s.read_data_1), 32'd0);
        check("small.rd6_zero", 32'(bus_s.read_data_2), 32'd0);
        bus_s.signal_reg_write = 1'b1;
        bus_s.write_reg        = 3'd7;
        bus_s.write_data       = 16'hA5A5;
        @(posedge clk);
        #1;
        bus_s.signal_reg_write = 1'b0;
        bus_s.read_reg_2       = 3'd7;
        #1;
        check("small.rd1_a5a5", 32'(bus_s.read_data_1), 32'h0000_A5A5);
        check("small.rd2_a5a5", 32'(bus_s.read_data_2), 32'h0000_A5A5);
        bus_s.signal_reg_write = 1'b1;
        bus_s.write_reg        = 3'd0;
        bus_s.write_data       = 16'h1234;
        @(posedge clk);
        #1;
        bus_s.signal_reg_write = 1'b0;
        bus_s.read_reg_1       = 3'd0;
        #1;
        check("small.rd0", 32'(bus_s.read_data_1), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/mips_register_bank.md
MIPS_REGISTER_BANK -- requirements
Module: mips_register_bank

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: width of each register and of every data port.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5: register index width; DEPTH = 2**ADDR_WIDTH entries.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset, sampled on rising clk.
REQ-005 The block SHALL have port read_reg_1, input, ADDR_WIDTH: read port 1 index.
REQ-006 The block SHALL have port read_reg_2, input, ADDR_WIDTH: read port 2 index.
REQ-007 The block SHALL have port write_reg, input, ADDR_WIDTH: write index.
REQ-008 The block SHALL have port write_data, input, DATA_WIDTH: write value.
REQ-009 The block SHALL have port signal_reg_write, input, 1 bit: write enable.
REQ-010 The block SHALL have port read_data_1, output, DATA_WIDTH: data of read port 1.
REQ-011 The block SHALL have port read_data_2, output, DATA_WIDTH: data of read port 2.
REQ-012 The block SHALL have port ready, output, 1 bit: high once the post-reset clear sweep is complete.

Function
REQ-013 Reads SHALL be combinational, with zero-cycle latency from read_reg_x to read_data_x.
REQ-014 Register 0 SHALL read as all-zero at all times, and writes to index 0 SHALL be discarded.
REQ-015 In READY, a write with signal_reg_write=1 and write_reg!=0 SHALL update the entry on the rising clk edge; the new value is visible to reads from the next cycle.
REQ-016 The FSM SHALL have two states: CLEAR and READY; ready=1 only in READY.
REQ-017 In CLEAR, each rising edge with rst=0 SHALL zero the entry at clear_idx and increment clear_idx; the edge that zeroes entry DEPTH-1 SHALL move the FSM to READY.
REQ-018 The clear sweep SHALL take exactly DEPTH-1 edges after rst deasserts (31 with default parameters).
REQ-019 While in CLEAR, signal_reg_write SHALL be ignored and both read_data outputs SHALL be forced to 0.
REQ-020 Index comparison SHALL use exactly ADDR_WIDTH bits, with no wrap beyond DEPTH-1; clear_idx SHALL be ADDR_WIDTH bits wide.
REQ-021 When both read ports address the same index, both SHALL return identical data.

Reset
REQ-022 On any rising edge with rst=1, the block SHALL set state=CLEAR, clear_idx=1 and ready=0; read_data_1 and read_data_2 read 0 from that edge onward.
REQ-023 Array contents SHALL NOT be modified on edges where rst=1; zeroing occurs only via the sweep.
REQ-024 Reset asserted mid-sweep or in READY SHALL restart the sweep from clear_idx=1; a write coincident with rst=1 SHALL be discarded.

Configuration
REQ-025 Macro REGFILE_BYPASS_EN, when defined, SHALL add write-to-read forwarding: in READY, if signal_reg_write=1 and write_reg==read_reg_x and write_reg!=0, then read_data_x SHALL equal write_data in the same cycle.
REQ-026 When REGFILE_BYPASS_EN is undefined, read_data_x SHALL return the stored (pre-edge) value until the write edge; forwarding logic SHALL be absent.

Verification
REQ-027 Scenario: assert rst for 2 edges, then release -> ready=0 for 31 edges and 1 after the 31st; reads of indices 1..31 return 0x00000000.
REQ-028 Scenario: in READY, write 0xFF003FFF to index 30, then read read_reg_2=30 and read_reg_1=31 -> read_data_2=0xFF003FFF and read_data_1=0x00000000.
REQ-029 Scenario: write 0xDEADBEEF to index 0, then read index 0 -> 0x00000000.
REQ-030 Scenario: write 0x12345678 to index 5 while read_reg_1=5 -> same cycle 0x12345678 with REGFILE_BYPASS_EN defined, old value without it; 0x12345678 on the next cycle in both builds.
REQ-031 Scenario: assert rst at sweep edge 10, release it, and issue writes during CLEAR -> sweep restarts, ready rises 31 edges after release, and all entries read 0.
REQ-032 Scenario: parameters DATA_WIDTH=16, ADDR_WIDTH=3 -> sweep takes 7 edges; write 0xA5A5 to index 7 reads back as 0xA5A5.
